// File: rtl/flash_wb_bridge.sv
// flash_wb_bridge: Wishbone-classic slave that turns 32-bit flash window
// accesses into 16-bit read/program/erase command handshakes with the flash
// controller. Reads take two half-words, writes one or two programs (only
// halves with enabled bytes), erase-alias writes a single block erase.
module flash_wb_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [24:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic [21:0] fl_addr,
   output logic [15:0] fl_data_wt,
   input  logic [15:0] fl_data_rd,
   output logic        fl_is_read,
   output logic        fl_is_write,
   output logic        fl_is_erase,
   input  logic        fl_ack
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ_LO, S_REL_LO, S_REQ_HI, S_REL_HI, S_ACK
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic        r_erase;
   logic [20:0] r_adr_w;   // word address, adr[22:2]
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic [15:0] r_rd_lo;   // low half of a read, merged into wb_dat_o at the end

   logic w_req;
   logic w_in_req;
   logic w_unused;

   // A request is ignored while the previous ack is still on the bus, so a
   // strobe that has not yet dropped cannot start a second access.
   assign w_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign w_in_req = (r_state == S_REQ_LO) || (r_state == S_REQ_HI);
   assign w_unused = &{1'b0, wb_adr_i[23], wb_adr_i[0]};

   // Program data for one half: disabled bytes become FF, which leaves the
   // flash byte untouched because programming can only clear bits.
   function automatic logic [15:0] merge_half(input logic [15:0] d,
                                              input logic [1:0]  s);
      merge_half = {s[1] ? d[15:8] : 8'hFF, s[0] ? d[7:0] : 8'hFF};
   endfunction

   // Sequencer: latches the access, walks the half-word handshakes and
   // registers every output (commands follow the state one cycle later).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_erase     <= 1'b0;
         r_adr_w     <= '0;
         r_dat       <= '0;
         r_sel       <= '0;
         r_rd_lo     <= '0;
         wb_dat_o    <= '0;
         wb_ack_o    <= 1'b0;
         fl_addr     <= '0;
         fl_data_wt  <= '0;
         fl_is_read  <= 1'b0;
         fl_is_write <= 1'b0;
         fl_is_erase <= 1'b0;
      end else begin
         fl_is_read  <= w_in_req & ~r_we;
         fl_is_write <= w_in_req & r_we & ~r_erase;
         fl_is_erase <= w_in_req & r_we & r_erase;
         wb_ack_o    <= (r_state == S_ACK);

         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_we    <= wb_we_i;
                  r_erase <= wb_adr_i[24];
                  r_adr_w <= wb_adr_i[22:2];
                  r_dat   <= wb_dat_i;
                  r_sel   <= wb_sel_i;
                  if (!wb_we_i) begin
                     fl_addr <= {wb_adr_i[22:2], 1'b0};
                     r_state <= S_REQ_LO;
                  end else if (wb_adr_i[24]) begin
                     fl_addr <= wb_adr_i[22:1];
                     r_state <= S_REQ_LO;
                  end else if (wb_sel_i == 4'b0000) begin
                     r_state <= S_ACK;
                  end else if (wb_sel_i[1:0] == 2'b00) begin
                     fl_addr    <= {wb_adr_i[22:2], 1'b1};
                     fl_data_wt <= merge_half(wb_dat_i[31:16], wb_sel_i[3:2]);
                     r_state    <= S_REQ_HI;
                  end else begin
                     fl_addr    <= {wb_adr_i[22:2], 1'b0};
                     fl_data_wt <= merge_half(wb_dat_i[15:0], wb_sel_i[1:0]);
                     r_state    <= S_REQ_LO;
                  end
               end
            end
            S_REQ_LO: begin
               if (fl_ack) begin
                  if (!r_we) r_rd_lo <= fl_data_rd;
                  r_state <= S_REL_LO;
               end
            end
            S_REL_LO: begin
               if (!fl_ack) begin
                  if (!r_we || (!r_erase && (r_sel[3:2] != 2'b00))) begin
                     fl_addr    <= {r_adr_w, 1'b1};
                     fl_data_wt <= merge_half(r_dat[31:16], r_sel[3:2]);
                     r_state    <= S_REQ_HI;
                  end else begin
                     r_state <= S_ACK;
                  end
               end
            end
            S_REQ_HI: begin
               if (fl_ack) begin
                  if (!r_we) wb_dat_o <= {fl_data_rd, r_rd_lo};
                  r_state <= S_REL_HI;
               end
            end
            S_REL_HI: begin
               if (!fl_ack) r_state <= S_ACK;
            end
            S_ACK:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
